// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: MEM stage of the 5-stage pipeline.
// Holds the EX/MEM latch, runs the data-memory req/ack handshake for loads and
// stores, produces the registered MEM/WB bundle and stalls upstream while a
// memory access is outstanding. A bus timeout forces completion so a dead
// memory cannot hang the CPU.
module pipe_mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        evalid,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  eGPR,
  output logic        mem_stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wvalid,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wGPR,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic        mvalid;
  logic        mwreg;
  logic        mm2reg;
  logic        mwmem;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [4:0]  mGPR;

  logic          mop;
  logic          is_load;
  logic          timeout;
  logic          done;
  logic [CW-1:0] cnt_eff;

  // Memory handshake and stall decode from the M latch; a load wins over a store
  always_comb begin
    mop       = mvalid & (mm2reg | mwmem);
    is_load   = mvalid & mm2reg;
    dm_req    = mop;
    dm_we     = mwmem & ~mm2reg;
    dm_addr   = {malu[31:2], 2'b00};
    dm_wdata  = mb;
    cnt_eff   = (state == WAIT) ? cnt : '0;
    timeout   = dm_req & ~dm_ack & (cnt_eff == CNT_LAST);
    done      = mop & (dm_ack | timeout);
    mem_stall = mop & ~done;
  end

  // EX/MEM latch: loads every unstalled edge, bubbles carry no control bits
  always_ff @(posedge clk) begin
    if (rst) begin
      mvalid <= 1'b0;
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
      malu   <= '0;
      mb     <= '0;
      mGPR   <= '0;
    end else if (!mem_stall) begin
      mvalid <= evalid;
      mwreg  <= evalid & ewreg;
      mm2reg <= evalid & em2reg;
      mwmem  <= evalid & ewmem;
      malu   <= ealu;
      mb     <= eb;
      mGPR   <= eGPR;
    end
  end

  // Access FSM and pending-cycle counter; a zero-wait ack never leaves IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mop && !done) begin
            state <= WAIT;
            cnt   <= cnt_eff + 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        WAIT: begin
          if (!mop || done) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_eff + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // MEM/WB register: bubble while stalled so a pending access writes back once
  always_ff @(posedge clk) begin
    if (rst || mem_stall) begin
      wvalid  <= 1'b0;
      wwreg   <= 1'b0;
      wm2reg  <= 1'b0;
      wmo     <= '0;
      walu    <= '0;
      wGPR    <= '0;
      bus_err <= 1'b0;
    end else begin
      wvalid  <= mvalid;
      wwreg   <= mvalid & mwreg;
      wm2reg  <= mm2reg;
      wmo     <= (is_load && dm_ack) ? dm_rdata : 32'h0;
      walu    <= malu;
      wGPR    <= mGPR;
      bus_err <= timeout;
    end
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// tb_pipe_mem_stage: directed self-checking bench for the MEM pipeline stage.
module tb_pipe_mem_stage;

  logic        clk;
  logic        rst;
  logic        evalid;
  logic        ewreg;
  logic        em2reg;
  logic        ewmem;
  logic [31:0] ealu;
  logic [31:0] eb;
  logic [4:0]  eGPR;
  logic        mem_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        wvalid;
  logic        wwreg;
  logic        wm2reg;
  logic [31:0] wmo;
  logic [31:0] walu;
  logic [4:0]  wGPR;
  logic        bus_err;

  int checks;
  int failures;

  pipe_mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .evalid(evalid), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealu(ealu), .eb(eb), .eGPR(eGPR),
    .mem_stall(mem_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wvalid(wvalid), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo),
    .walu(walu), .wGPR(wGPR), .bus_err(bus_err)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so a stuck run still ends with a report
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic wr, input logic ld, input logic st,
                               input logic [31:0] alu, input logic [31:0] b, input logic [4:0] gpr);
    evalid = v;
    ewreg  = wr;
    em2reg = ld;
    ewmem  = st;
    ealu   = alu;
    eb     = b;
    eGPR   = gpr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int req_cycles;
    int stall_cycles;
    int err_pulses;
    logic [31:0] wmo_at_err;
    logic        wvalid_at_err;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    dm_ack   = 1'b0;
    dm_rdata = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

    // Reset state
    step();
    step();
    checkOutput("rst_wvalid", {31'b0, wvalid}, 32'd0);
    checkOutput("rst_dm_req", {31'b0, dm_req}, 32'd0);
    checkOutput("rst_stall", {31'b0, mem_stall}, 32'd0);
    checkOutput("rst_bus_err", {31'b0, bus_err}, 32'd0);
    checkOutput("rst_walu", walu, 32'd0);
    rst = 1'b0;

    // Plain ALU op: two edges E->W, no memory activity
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 5'd8);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    checkOutput("alu_dm_req", {31'b0, dm_req}, 32'd0);
    checkOutput("alu_stall", {31'b0, mem_stall}, 32'd0);
    checkOutput("alu_w_early", {31'b0, wvalid}, 32'd0);
    step();
    checkOutput("alu_wvalid", {31'b0, wvalid}, 32'd1);
    checkOutput("alu_wwreg", {31'b0, wwreg}, 32'd1);
    checkOutput("alu_walu", walu, 32'h10);
    checkOutput("alu_wGPR", {27'b0, wGPR}, 32'd8);

    // Zero-wait load with an unaligned address
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 5'd9);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    dm_ack   = 1'b1;
    dm_rdata = 32'hDEAD_BEEF;
    #1;
    checkOutput("ld0_dm_req", {31'b0, dm_req}, 32'd1);
    checkOutput("ld0_dm_addr", dm_addr, 32'h100);
    checkOutput("ld0_dm_we", {31'b0, dm_we}, 32'd0);
    checkOutput("ld0_stall", {31'b0, mem_stall}, 32'd0);
    step();
    dm_ack = 1'b0;
    #1;
    checkOutput("ld0_wvalid", {31'b0, wvalid}, 32'd1);
    checkOutput("ld0_wm2reg", {31'b0, wm2reg}, 32'd1);
    checkOutput("ld0_wmo", wmo, 32'hDEAD_BEEF);
    checkOutput("ld0_wGPR", {27'b0, wGPR}, 32'd9);
    checkOutput("ld0_req_drop", {31'b0, dm_req}, 32'd0);

    // Store with a 3-cycle ack delay; next ALU instruction held in E meanwhile
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_1234, 5'd0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 5'd3);
    req_cycles   = 0;
    stall_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      dm_ack = (i == 3);
      #1;
      if (dm_req && dm_we) req_cycles++;
      if (mem_stall) stall_cycles++;
      checkOutput($sformatf("st_wdata_%0d", i), dm_wdata, 32'h1234);
      checkOutput($sformatf("st_addr_%0d", i), dm_addr, 32'h200);
      step();
      if (i < 3) checkOutput($sformatf("st_bubble_%0d", i), {31'b0, wvalid}, 32'd0);
    end
    dm_ack = 1'b0;
    checkOutput("st_req_cycles", req_cycles, 32'd4);
    checkOutput("st_stall_cycles", stall_cycles, 32'd3);
    checkOutput("st_wvalid", {31'b0, wvalid}, 32'd1);
    checkOutput("st_wwreg", {31'b0, wwreg}, 32'd0);
    checkOutput("st_wm2reg", {31'b0, wm2reg}, 32'd0);
    checkOutput("st_walu", walu, 32'h200);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    checkOutput("held_wvalid", {31'b0, wvalid}, 32'd1);
    checkOutput("held_walu", walu, 32'h55);
    checkOutput("held_wGPR", {27'b0, wGPR}, 32'd3);

    // Load against a dead memory: forced completion after 16 request cycles
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd5);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    dm_rdata      = 32'hBAD0_BAD0;
    req_cycles    = 0;
    err_pulses    = 0;
    wmo_at_err    = 32'hFFFF_FFFF;
    wvalid_at_err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dm_req) req_cycles++;
      step();
      if (bus_err) begin
        err_pulses++;
        wmo_at_err    = wmo;
        wvalid_at_err = wvalid;
      end
    end
    checkOutput("to_req_cycles", req_cycles, 32'd16);
    checkOutput("to_err_pulses", err_pulses, 32'd1);
    checkOutput("to_wmo", wmo_at_err, 32'd0);
    checkOutput("to_wvalid", {31'b0, wvalid_at_err}, 32'd1);
    checkOutput("to_resume_stall", {31'b0, mem_stall}, 32'd0);

    // Reset during the second wait cycle of a load
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd6);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    checkOutput("rm_in_wait", {31'b0, mem_stall}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rm_dm_req", {31'b0, dm_req}, 32'd0);
    checkOutput("rm_wvalid", {31'b0, wvalid}, 32'd0);
    checkOutput("rm_stall", {31'b0, mem_stall}, 32'd0);
    dm_ack   = 1'b1;
    dm_rdata = 32'h0000_CAFE;
    step();
    dm_ack = 1'b0;
    checkOutput("rm_late_wvalid", {31'b0, wvalid}, 32'd0);
    checkOutput("rm_late_wmo", wmo, 32'd0);
    step();
    checkOutput("rm_after_wvalid", {31'b0, wvalid}, 32'd0);

    // Back-to-back lw then sw, one wait cycle each
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 5'd7);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0504, 32'h0000_A5A5, 5'd0);
    dm_ack = 1'b0;
    #1;
    checkOutput("bb_lw_addr", dm_addr, 32'h500);
    checkOutput("bb_lw_we", {31'b0, dm_we}, 32'd0);
    checkOutput("bb_lw_stall", {31'b0, mem_stall}, 32'd1);
    step();
    dm_ack   = 1'b1;
    dm_rdata = 32'h1111_2222;
    #1;
    checkOutput("bb_lw_done", {31'b0, mem_stall}, 32'd0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    dm_ack = 1'b0;
    #1;
    checkOutput("bb_lw_wvalid", {31'b0, wvalid}, 32'd1);
    checkOutput("bb_lw_wmo", wmo, 32'h1111_2222);
    checkOutput("bb_lw_wGPR", {27'b0, wGPR}, 32'd7);
    checkOutput("bb_sw_req", {31'b0, dm_req}, 32'd1);
    checkOutput("bb_sw_we", {31'b0, dm_we}, 32'd1);
    checkOutput("bb_sw_addr", dm_addr, 32'h504);
    checkOutput("bb_sw_wdata", dm_wdata, 32'hA5A5);
    step();
    checkOutput("bb_sw_bubble", {31'b0, wvalid}, 32'd0);
    dm_ack = 1'b1;
    #1;
    step();
    dm_ack = 1'b0;
    checkOutput("bb_sw_wvalid", {31'b0, wvalid}, 32'd1);
    checkOutput("bb_sw_wwreg", {31'b0, wwreg}, 32'd0);
    checkOutput("bb_sw_walu", walu, 32'h504);
    checkOutput("bb_sw_wmo", wmo, 32'd0);
    step();
    checkOutput("bb_no_dup", {31'b0, wvalid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
